// File: rtl/lynxTypes.sv
// lynxTypes -- shared bus-width constants for the host-write data path.
// Ports: none (package only).
package lynxTypes;

    localparam int VADDR_BITS    = 48;
    localparam int LEN_BITS      = 28;
    localparam int AXI_DATA_BITS = 512;

endpackage

// File: rtl/rdma_scatter_dispatcher_pkg.sv
// rdma_scatter_dispatcher_pkg -- FSM state type, segment count and the
// segment byte-length helper shared by the scatter dispatcher.
// Ports: none (package only).
package rdma_scatter_dispatcher_pkg;

    import lynxTypes::*;

    localparam int N_SEG         = 4;
    localparam int SEG_BEATS_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_DATA = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // Bytes carried by one segment of 'beats' full-width beats.
    function automatic logic [LEN_BITS-1:0] seg_bytes(input int beats);
        return LEN_BITS'(beats * (AXI_DATA_BITS / 8));
    endfunction

endpackage

// File: rtl/rdma_scatter_dispatcher.sv
// rdma_scatter_dispatcher -- splits one incoming RDMA payload stream into
// N_SEG fixed-size segments, issuing one local write descriptor per segment
// (destination vaddr taken from the host-programmed table) and forwarding
// the payload beats unregistered toward the host-write path.
//
// Ports:
//   aclk, aresetn              clock, async active-low reset
//   bench_vaddr_1..4           segment 0..3 destination vaddrs
//   bench_vaddr_valid          level; rising edge arms a scatter (IDLE only)
//   s_axis_*                   incoming payload stream
//   m_axis_*                   outgoing payload stream
//   req_vaddr/len/valid/ready  per-segment write descriptor
//   busy                       scatter in progress
//   done                       one-cycle completion pulse
//   err                        sticky premature-tlast flag
//   done_cnt                   completed scatters (wraps)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a rising edge on bench_vaddr_valid
// REQ   | presenting the descriptor for segment seg
// DATA  | forwarding beats of segment seg
// DONE  | last segment finished; done pulse, count completion
// ERR   | premature tlast seen; one cycle back to IDLE, no done
module rdma_scatter_dispatcher
    import lynxTypes::*;
    import rdma_scatter_dispatcher_pkg::*;
#(
    parameter int SEG_BEATS = SEG_BEATS_DEF,
    parameter int N_SEG     = rdma_scatter_dispatcher_pkg::N_SEG
) (
    input  logic                       aclk,
    input  logic                       aresetn,

    input  logic [VADDR_BITS-1:0]      bench_vaddr_1,
    input  logic [VADDR_BITS-1:0]      bench_vaddr_2,
    input  logic [VADDR_BITS-1:0]      bench_vaddr_3,
    input  logic [VADDR_BITS-1:0]      bench_vaddr_4,
    input  logic                       bench_vaddr_valid,

    input  logic [AXI_DATA_BITS-1:0]   s_axis_tdata,
    input  logic [AXI_DATA_BITS/8-1:0] s_axis_tkeep,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,

    output logic [AXI_DATA_BITS-1:0]   m_axis_tdata,
    output logic [AXI_DATA_BITS/8-1:0] m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,

    output logic [VADDR_BITS-1:0]      req_vaddr,
    output logic [LEN_BITS-1:0]        req_len,
    output logic                       req_valid,
    input  logic                       req_ready,

    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [31:0]                done_cnt
);

    localparam int                    BEAT_W    = (SEG_BEATS > 1) ? $clog2(SEG_BEATS) : 1;
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(SEG_BEATS - 1);
    localparam logic [1:0]            LAST_SEG  = 2'(N_SEG - 1);
    localparam logic [LEN_BITS-1:0]   SEG_LEN   = seg_bytes(SEG_BEATS);

    state_t                  state_q, state_d;
    logic [1:0]              seg_q;
    logic [BEAT_W-1:0]       beat_q;
    logic [VADDR_BITS-1:0]   vaddr_q [4];
    logic                    vld_q;
    logic                    sampled_q;
    logic                    err_q;
    logic [31:0]             done_cnt_q;

    logic arm;
    logic beat_hs;
    logic last_beat;
    logic tlast_ok;
    logic premature;

    // sampled_q blocks arming on the first cycle after reset, so a valid
    // already high at release is recorded but not taken as an edge.
    assign arm       = (state_q == ST_IDLE) && sampled_q && !vld_q && bench_vaddr_valid;
    assign beat_hs   = (state_q == ST_DATA) && s_axis_tvalid && m_axis_tready;
    assign last_beat = (beat_q == LAST_BEAT);
    assign tlast_ok  = last_beat && (seg_q == LAST_SEG);
    assign premature = beat_hs && s_axis_tlast && !tlast_ok;

    always_comb begin
        state_d       = state_q;
        req_valid     = 1'b0;
        req_vaddr     = '0;
        req_len       = '0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (arm) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                req_valid = 1'b1;
                req_vaddr = vaddr_q[seg_q];
                req_len   = SEG_LEN;
                if (req_ready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tkeep  = s_axis_tkeep;
                // A premature tlast is still forwarded as a frame end.
                m_axis_tlast  = last_beat || s_axis_tlast;
                if (premature) begin
                    state_d = ST_ERR;
                end else if (beat_hs && last_beat) begin
                    state_d = (seg_q == LAST_SEG) ? ST_DONE : ST_REQ;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            seg_q      <= '0;
            beat_q     <= '0;
            vld_q      <= 1'b0;
            sampled_q  <= 1'b0;
            err_q      <= 1'b0;
            done_cnt_q <= '0;
            for (int i = 0; i < 4; i++) begin
                vaddr_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            vld_q     <= bench_vaddr_valid;
            sampled_q <= 1'b1;

            if (arm) begin
                vaddr_q[0] <= bench_vaddr_1;
                vaddr_q[1] <= bench_vaddr_2;
                vaddr_q[2] <= bench_vaddr_3;
                vaddr_q[3] <= bench_vaddr_4;
                seg_q      <= '0;
                beat_q     <= '0;
                err_q      <= 1'b0;
            end else if (beat_hs) begin
                if (premature) begin
                    err_q <= 1'b1;
                end else if (last_beat) begin
                    beat_q <= '0;
                    seg_q  <= seg_q + 2'd1;
                end else begin
                    beat_q <= beat_q + BEAT_W'(1);
                end
            end

            if (state_q == ST_DONE) begin
                done_cnt_q <= done_cnt_q + 32'd1;
            end
        end
    end

    assign err      = err_q;
    assign done_cnt = done_cnt_q;

endmodule

// File: tb/tb_rdma_scatter_dispatcher.sv
module tb_rdma_scatter_dispatcher;
    import lynxTypes::*;

    localparam int SB = 64;
    localparam int NB = 4 * SB;
    localparam int KB = AXI_DATA_BITS / 8;
    localparam int BW = AXI_DATA_BITS + KB + 1;
    typedef logic [BW-1:0] beat_t;

    logic                     aclk = 1'b0;
    logic                     aresetn = 1'b0;
    logic [VADDR_BITS-1:0]    bench_vaddr_1 = '0, bench_vaddr_2 = '0, bench_vaddr_3 = '0, bench_vaddr_4 = '0;
    logic                     bench_vaddr_valid = 1'b0;
    logic [AXI_DATA_BITS-1:0] s_axis_tdata = '0;
    logic [KB-1:0]            s_axis_tkeep = '0;
    logic                     s_axis_tlast = 1'b0, s_axis_tvalid = 1'b0, s_axis_tready;
    logic [AXI_DATA_BITS-1:0] m_axis_tdata;
    logic [KB-1:0]            m_axis_tkeep;
    logic                     m_axis_tlast, m_axis_tvalid;
    logic                     m_axis_tready = 1'b0;
    logic [VADDR_BITS-1:0]    req_vaddr;
    logic [LEN_BITS-1:0]      req_len;
    logic                     req_valid;
    logic                     req_ready = 1'b0;
    logic                     busy, done, err;
    logic [31:0]              done_cnt;

    always #5 aclk = ~aclk;

    rdma_scatter_dispatcher #(.SEG_BEATS(SB), .N_SEG(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .bench_vaddr_1(bench_vaddr_1), .bench_vaddr_2(bench_vaddr_2),
        .bench_vaddr_3(bench_vaddr_3), .bench_vaddr_4(bench_vaddr_4),
        .bench_vaddr_valid(bench_vaddr_valid),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .req_vaddr(req_vaddr), .req_len(req_len), .req_valid(req_valid), .req_ready(req_ready),
        .busy(busy), .done(done), .err(err), .done_cnt(done_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input beat_t got, input beat_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observer: records accepted descriptors, forwarded beats and done pulses.
    logic [VADDR_BITS-1:0] got_desc[$];
    beat_t                 got_beats[$];
    int                    done_pulses = 0;
    logic                  stall_prev = 1'b0;
    logic [VADDR_BITS-1:0] vaddr_prev = '0;

    always @(negedge aclk) begin
        if (aresetn) begin
            if (stall_prev) begin
                check_val("req_hold_valid", beat_t'(req_valid), beat_t'(1));
                check_val("req_hold_vaddr", beat_t'(req_vaddr), beat_t'(vaddr_prev));
            end
            if (req_valid && req_ready) begin
                got_desc.push_back(req_vaddr);
                check_val("req_len", beat_t'(req_len), beat_t'(4096));
            end
            if (m_axis_tvalid && m_axis_tready)
                got_beats.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
            if (done) done_pulses++;
            stall_prev = req_valid && !req_ready;
            vaddr_prev = req_vaddr;
        end else begin
            stall_prev = 1'b0;
        end
    end

    logic [VADDR_BITS-1:0] va [4];
    int exp_done_cnt = 0;

    task automatic gen_beat(output logic [AXI_DATA_BITS-1:0] d, output logic [KB-1:0] k);
        for (int w = 0; w < AXI_DATA_BITS / 32; w++) d[w*32 +: 32] = $urandom;
        k = {$urandom, $urandom};
    endtask

    task automatic arm_scatter();
        req_ready = 1'b0;
        bench_vaddr_valid = 1'b0;
        @(posedge aclk); #1;
        bench_vaddr_1 = va[0]; bench_vaddr_2 = va[1];
        bench_vaddr_3 = va[2]; bench_vaddr_4 = va[3];
        bench_vaddr_valid = 1'b1;
        got_desc.delete(); got_beats.delete(); done_pulses = 0;
        @(posedge aclk); #1;
        check_val("arm_latency", beat_t'(req_valid), beat_t'(1));
        check_val("err_cleared_on_arm", beat_t'(err), beat_t'(0));
    endtask

    // Sends n_send beats; tlast goes on err_at (premature) or on the final beat.
    task automatic stream(input int n_send, input int err_at, input bit stall,
                          input bit rearm, input int rst_at);
        beat_t exp_q[$];
        int i = 0, cyc = 0, rq_wait = 0, n_desc;
        bit rst_hit = 0;
        logic [AXI_DATA_BITS-1:0] d;
        logic [KB-1:0] k;
        int last_idx = (err_at >= 0) ? err_at : NB - 1;
        gen_beat(d, k);
        while (i < n_send && cyc < 4000) begin
            if (i == rst_at) begin
                aresetn = 1'b0;
                s_axis_tvalid = 1'b0;
                #1;
                check_val("rst_req_valid", beat_t'(req_valid), beat_t'(0));
                check_val("rst_m_tvalid", beat_t'(m_axis_tvalid), beat_t'(0));
                check_val("rst_s_tready", beat_t'(s_axis_tready), beat_t'(0));
                check_val("rst_busy", beat_t'(busy), beat_t'(0));
                check_val("rst_done_cnt", beat_t'(done_cnt), beat_t'(0));
                exp_done_cnt = 0;
                rst_hit = 1;
                break;
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = d;
            s_axis_tkeep  = k;
            s_axis_tlast  = (i == last_idx);
            m_axis_tready = stall ? ~m_axis_tready : 1'b1;
            req_ready     = stall ? (rq_wait >= 10) : 1'b1;
            if (rearm && i >= 70 && i < 75) begin
                bench_vaddr_valid = 1'b0;
                bench_vaddr_1 = 48'hA000; bench_vaddr_2 = 48'hB000;
                bench_vaddr_3 = 48'hC000; bench_vaddr_4 = 48'hD000;
            end else if (rearm && i >= 75) begin
                bench_vaddr_valid = 1'b1;
            end
            @(negedge aclk);
            if (req_valid && req_ready) rq_wait = 0;
            else if (req_valid) rq_wait++;
            if (s_axis_tvalid && s_axis_tready) begin
                exp_q.push_back({((i % SB) == SB - 1) || (i == err_at), k, d});
                i++;
                gen_beat(d, k);
            end
            @(posedge aclk); #1;
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (rst_hit) begin
            repeat (3) @(posedge aclk);
            #1;
            got_desc.delete();
            aresetn = 1'b1;
            repeat (20) @(posedge aclk);
            #1;
            check_val("no_arm_after_reset", beat_t'(got_desc.size()), beat_t'(0));
            check_val("idle_after_reset", beat_t'(busy), beat_t'(0));
            return;
        end
        check_val("beat_budget", beat_t'(i), beat_t'(n_send));
        for (int c = 0; c < 50 && busy; c++) @(negedge aclk);
        check_val("return_idle", beat_t'(busy), beat_t'(0));

        check_val("beat_count", beat_t'(got_beats.size()), beat_t'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && j < got_beats.size(); j++)
            check_val("beat", got_beats[j], exp_q[j]);

        n_desc = (err_at >= 0) ? (err_at / SB + 1) : 4;
        check_val("desc_count", beat_t'(got_desc.size()), beat_t'(n_desc));
        for (int j = 0; j < n_desc && j < got_desc.size(); j++)
            check_val("desc_vaddr", beat_t'(got_desc[j]), beat_t'(va[j]));

        if (err_at < 0) exp_done_cnt++;
        check_val("done_pulses", beat_t'(done_pulses), beat_t'((err_at < 0) ? 1 : 0));
        check_val("done_cnt", beat_t'(done_cnt), beat_t'(exp_done_cnt));
        check_val("err_flag", beat_t'(err), beat_t'((err_at >= 0) ? 1 : 0));
    endtask

    task automatic set_default_vaddrs();
        va[0] = 48'h1000; va[1] = 48'h2000; va[2] = 48'h3000; va[3] = 48'h4000;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge aclk);
        #1;
        check_val("reset_busy", beat_t'(busy), beat_t'(0));
        check_val("reset_req_valid", beat_t'(req_valid), beat_t'(0));
        check_val("reset_err", beat_t'(err), beat_t'(0));
        check_val("reset_done_cnt", beat_t'(done_cnt), beat_t'(0));
        check_val("reset_s_tready", beat_t'(s_axis_tready), beat_t'(0));
        aresetn = 1'b1;
        repeat (3) @(posedge aclk);
        #1;

        set_default_vaddrs();
        arm_scatter(); stream(NB, -1, 0, 0, -1);     // continuous
        arm_scatter(); stream(NB, -1, 1, 0, -1);     // descriptor and sink stalls
        arm_scatter(); stream(101, 100, 0, 0, -1);   // premature tlast on beat 100
        arm_scatter(); stream(NB, -1, 0, 1, -1);     // re-arm attempt during segment 1

        for (int j = 0; j < 4; j++) va[j] = VADDR_BITS'({$urandom, $urandom});
        begin
            int e = $urandom_range(0, NB - 2);
            arm_scatter(); stream(e + 1, e, 1, 0, -1);
        end

        set_default_vaddrs();
        arm_scatter(); stream(NB, -1, 0, 0, 2 * SB + 30);  // reset mid segment 2

        for (int s = 0; s < 3; s++) begin
            for (int j = 0; j < 4; j++) va[j] = VADDR_BITS'({$urandom, $urandom});
            arm_scatter(); stream(NB, -1, bit'($urandom_range(0, 1)), 0, -1);
        end
        check_val("done_cnt_after_three", beat_t'(done_cnt), beat_t'(3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
